// File: rtl/psum_accum_collector.sv
// Partial-sum collector: accumulates K signed products per sum, N sums per job,
// and queues finished sums in a small first-word-fall-through FIFO.
//   state | meaning
//   IDLE  | waiting for start; FIFO may still drain; stray samples flagged
//   RUN   | accumulating samples, pushing one sum every k_len samples
`ifndef SYSTOLIC_PSUM_WIDTH
`define SYSTOLIC_PSUM_WIDTH 16
`endif

module psum_accum_collector #(
  parameter int IN_W       = `SYSTOLIC_PSUM_WIDTH,
  parameter int K_MAX      = 256,
  parameter int N_MAX      = 1024,
  parameter int FIFO_DEPTH = 4,
  localparam int ACC_W     = IN_W + $clog2(K_MAX),
  localparam int KW        = $clog2(K_MAX) + 1,
  localparam int NW        = $clog2(N_MAX) + 1
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic             start,
  input  logic [KW-1:0]    cfg_k_len,
  input  logic [NW-1:0]    cfg_n_len,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_vld,
  output logic [ACC_W-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done,
  output logic             err_ovf,
  output logic             err_unexp
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_len_q, k_len_d;
  logic [NW-1:0]      n_len_q, n_len_d;
  logic [KW-1:0]      k_cnt_q, k_cnt_d;
  logic [NW-1:0]      n_cnt_q, n_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               done_q, done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_unexp_q, err_unexp_d;
  logic [ACC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ACC_W-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               start_ok;
  logic               last_k;
  logic               last_n;
  logic               push_req;
  logic               pop;
  logic               full;
  logic               do_push;
  logic [ACC_W-1:0]   acc_next;

  assign start_ok = start && (cfg_k_len != '0) && (cfg_n_len != '0);
  assign last_k   = (k_cnt_q == k_len_q - KW'(1));
  assign last_n   = (n_cnt_q == n_len_q - NW'(1));
  assign push_req = (state_q == RUN) && in_vld && last_k;
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign pop      = (cnt_q != '0) && out_rdy;
  // A full FIFO can still take a sum when the head leaves in the same cycle.
  assign do_push  = push_req && (!full || pop);
  assign acc_next = acc_q + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (push_req && last_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_len_d     = k_len_q;
    n_len_d     = n_len_q;
    k_cnt_d     = k_cnt_q;
    n_cnt_d     = n_cnt_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_unexp_d = err_unexp_q;
    if (state_q == IDLE) begin
      if (start_ok) begin
        k_len_d     = cfg_k_len;
        n_len_d     = cfg_n_len;
        k_cnt_d     = '0;
        n_cnt_d     = '0;
        acc_d       = '0;
        err_ovf_d   = 1'b0;
        err_unexp_d = 1'b0;
      end
      if (in_vld) err_unexp_d = 1'b1;
    end else if (in_vld) begin
      if (last_k) begin
        acc_d   = '0;
        k_cnt_d = '0;
        // Counters advance even on a dropped sum so the job stays aligned.
        n_cnt_d = n_cnt_q + NW'(1);
        if (last_n) done_d = 1'b1;
        if (!do_push) err_ovf_d = 1'b1;
      end else begin
        acc_d   = acc_next;
        k_cnt_d = k_cnt_q + KW'(1);
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = acc_next;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(pop);
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      k_len_q     <= '0;
      n_len_q     <= '0;
      k_cnt_q     <= '0;
      n_cnt_q     <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      k_len_q     <= k_len_d;
      n_len_q     <= n_len_d;
      k_cnt_q     <= k_cnt_d;
      n_cnt_q     <= n_cnt_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = done_q;
    err_ovf   = err_ovf_q;
    err_unexp = err_unexp_q;
    out_vld   = (cnt_q != '0);
    out_data  = mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_psum_accum_collector.sv
// Scenario bench for psum_accum_collector: expected sums are queued as samples
// are driven and compared as the FIFO hands them out.
module tb_psum_accum_collector;

  localparam int IN_W  = 16;
  localparam int K_MAX = 256;
  localparam int N_MAX = 1024;
  localparam int DEPTH = 4;
  localparam int ACC_W = IN_W + $clog2(K_MAX);
  localparam int KW    = $clog2(K_MAX) + 1;
  localparam int NW    = $clog2(N_MAX) + 1;

  logic             s_clk = 1'b0;
  logic             s_rst = 1'b1;
  logic             start = 1'b0;
  logic [KW-1:0]    cfg_k_len = '0;
  logic [NW-1:0]    cfg_n_len = '0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_vld = 1'b0;
  logic [ACC_W-1:0] out_data;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic             busy;
  logic             done;
  logic             err_ovf;
  logic             err_unexp;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ACC_W-1:0] sb[$];

  psum_accum_collector #(.IN_W(IN_W), .K_MAX(K_MAX), .N_MAX(N_MAX), .FIFO_DEPTH(DEPTH)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .start(start), .cfg_k_len(cfg_k_len),
    .cfg_n_len(cfg_n_len), .in_data(in_data), .in_vld(in_vld),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy),
    .done(done), .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  always #5 s_clk = ~s_clk;

  // Scoreboard: every handshake seen here is popped by the DUT on the next edge.
  always @(negedge s_clk) begin
    if (done === 1'b1) done_cnt++;
    if (out_vld === 1'b1 && out_rdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%0d expected=none", $signed(out_data));
      end else begin
        logic [ACC_W-1:0] e;
        e = sb.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL sb_data got=%0d expected=%0d", $signed(out_data), $signed(e));
        end
      end
    end
  end

  task automatic do_start(input int k, input int n);
    cfg_k_len = KW'(k);
    cfg_n_len = NW'(n);
    start = 1'b1;
    @(posedge s_clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int d);
    in_data = IN_W'(d);
    in_vld = 1'b1;
    @(posedge s_clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge s_clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int t;
    out_rdy = 1'b1;
    t = 0;
    while ((sb.size() != 0 || out_vld === 1'b1) && t < 40) begin
      idle(1);
      t++;
    end
    checks++;
    if (sb.size() != 0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain left=%0d out_vld=%b expected 0/0", name, sb.size(), out_vld);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, out_vld, err_ovf, err_unexp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=00000", {busy, done, out_vld, err_ovf, err_unexp});
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got=%0d expected=0", out_data);
    end
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int d0;
    out_rdy = 1'b1;
    d0 = done_cnt;
    do_start(4, 1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b expected=1", busy); end
    send(3); send(-5); send(7);
    sb.push_back(ACC_W'(7));
    send(2);
    checks++;
    if ({out_vld, done, busy} !== 3'b110) begin
      errors++;
      $display("FAIL basic_timing got vld/done/busy=%b expected=110", {out_vld, done, busy});
    end
    idle(1);
    checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b pulses=%0d expected 0/1", done, done_cnt - d0);
    end
    drain("basic");
  endtask

  task automatic test_sign_width();
    do_start(4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(ACC_W'(-131072));
      send(32'h8000);
    end
    drain("sign_min");
    do_start(1, 2);
    sb.push_back(ACC_W'(5));  send(5);
    sb.push_back(ACC_W'(-1)); send(-1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL k1_busy got=%b expected=0", busy); end
    drain("k1");
  endtask

  task automatic test_bubbles();
    int d0;
    int sum;
    d0 = done_cnt;
    out_rdy = 1'b1;
    do_start(3, 3);
    sum = 0;
    for (int i = 1; i <= 9; i++) begin
      sum += i;
      if (i % 3 == 0) begin
        sb.push_back(ACC_W'(sum));
        sum = 0;
      end
      send(i);
      idle($urandom_range(0, 2));
    end
    idle(2);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bubbles_done got pulses=%0d busy=%b expected 1/0", done_cnt - d0, busy);
    end
    drain("bubbles");
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    out_rdy = 1'b0;
    do_start(1, 6);
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(ACC_W'(i));
      send(i);
    end
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b expected=0", err_ovf); end
    send(5);
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b expected=1", err_ovf); end
    send(6);
    idle(1);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || out_vld !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end got pulses=%0d busy=%b vld=%b expected 1/0/1", done_cnt - d0, busy, out_vld);
    end
    drain("ovf");
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b expected=1", err_ovf); end
  endtask

  task automatic test_full_pop();
    out_rdy = 1'b0;
    do_start(1, 6);
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL fullpop_clear got=%b expected=0", err_ovf); end
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(ACC_W'(i));
      send(i);
    end
    out_rdy = 1'b1;
    for (int i = 5; i <= 6; i++) begin
      sb.push_back(ACC_W'(i));
      send(i);
    end
    drain("fullpop");
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b expected=0", err_ovf); end
  endtask

  task automatic test_control();
    out_rdy = 1'b1;
    do_start(0, 3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL k0_start got busy=%b expected=0", busy); end
    do_start(2, 0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL n0_start got busy=%b expected=0", busy); end
    send(9);
    checks++;
    if (err_unexp !== 1'b1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL unexp_set got err=%b vld=%b expected 1/0", err_unexp, out_vld);
    end
    do_start(1, 1);
    checks++;
    if (err_unexp !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL unexp_clear got err=%b busy=%b expected 0/1", err_unexp, busy);
    end
    do_start(2, 1);
    sb.push_back(ACC_W'(11));
    send(11);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run got busy=%b done=%b expected 0/1", busy, done);
    end
    drain("control");
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b1;
    do_start(4, 1);
    send(1); send(2);
    s_rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out_vld, err_ovf, err_unexp} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b data=%0d expected 00000/0",
               {busy, done, out_vld, err_ovf, err_unexp}, out_data);
    end
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    idle(1);
    do_start(2, 1);
    send(10);
    sb.push_back(ACC_W'(30));
    send(20);
    drain("midrst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_width();
    test_bubbles();
    test_overflow();
    test_full_pop();
    test_control();
    test_reset_mid();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
